// File: rtl/fetch_mem_port.sv
// fetch_mem_port: instruction-side memory port that sits between the fetch unit and
// a single-ported req/ack memory bus. It keeps two buffered words:
//  - the current word at pc_addr
//  - the prefetch word at pf_addr
// It stalls the fetch unit until both words match the requested addresses.
module fetch_mem_port #(
  parameter int ADDR_W = 16,
  parameter bit REUSE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] pf_addr,
  input  logic              flush,
  output logic [15:0]       fetch_opc,
  output logic [15:0]       prefetch_opc,
  output logic              hold,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata
);

  localparam int TAG_W = ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_PC = 2'd1,
    RD_PF = 2'd2
  } state_t;

  state_t            state;
  logic [TAG_W-1:0]  cur_tag;
  logic [15:0]       cur_data;
  logic              cur_v;
  logic [TAG_W-1:0]  pf_tag;
  logic [15:0]       pf_data;
  logic              pf_v;
  logic              flush_seen;

  logic [TAG_W-1:0]  pc_tag_in;
  logic [TAG_W-1:0]  pf_tag_in;
  logic [TAG_W-1:0]  bus_tag;
  logic              pc_hit;
  logic              pf_hit;
  logic              pc_from_pf;
  logic              flushed;
  logic              unused_bits;

  // Byte bit 0 never takes part in a compare, so only the word part of each address is kept.
  assign pc_tag_in   = pc_addr[ADDR_W-1:1];
  assign pf_tag_in   = pf_addr[ADDR_W-1:1];
  assign bus_tag     = mem_addr[ADDR_W-1:1];
  assign unused_bits = pc_addr[0] ^ pf_addr[0] ^ mem_addr[0];

  assign pc_hit     = cur_v & (pc_tag_in == cur_tag);
  assign pf_hit     = pf_v  & (pf_tag_in == pf_tag);
  assign pc_from_pf = REUSE & pf_v & (pc_tag_in == pf_tag);

  // A flush arriving in the same cycle as an ack counts as already seen.
  assign flushed = flush_seen | flush;

  assign hold         = ~((state == IDLE) & pc_hit & pf_hit & ~flush);
  assign fetch_opc    = cur_data;
  assign prefetch_opc = pf_data;

  // Single FSM owning the buffered words and the registered bus request/address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_tag    <= '0;
      cur_data   <= '0;
      cur_v      <= 1'b0;
      pf_tag     <= '0;
      pf_data    <= '0;
      pf_v       <= 1'b0;
      flush_seen <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          flush_seen <= 1'b0;
          if (flush) begin
            cur_v <= 1'b0;
            pf_v  <= 1'b0;
          end else if (!pc_hit && pc_from_pf) begin
            // The old prefetch word becomes the fetch word.
            // The prefetch slot is then empty, so its read is issued in the same cycle.
            cur_tag  <= pf_tag;
            cur_data <= pf_data;
            cur_v    <= 1'b1;
            pf_v     <= 1'b0;
            state    <= RD_PF;
            mem_req  <= 1'b1;
            mem_addr <= {pf_tag_in, 1'b0};
          end else if (!pc_hit) begin
            state    <= RD_PC;
            mem_req  <= 1'b1;
            mem_addr <= {pc_tag_in, 1'b0};
          end else if (!pf_hit) begin
            state    <= RD_PF;
            mem_req  <= 1'b1;
            mem_addr <= {pf_tag_in, 1'b0};
          end
        end

        RD_PC: begin
          if (flush) begin
            flush_seen <= 1'b1;
          end
          if (mem_ack) begin
            if (flushed) begin
              cur_v      <= 1'b0;
              pf_v       <= 1'b0;
              flush_seen <= 1'b0;
              mem_req    <= 1'b0;
              state      <= IDLE;
            end else begin
              cur_data <= mem_rdata;
              cur_tag  <= bus_tag;
              cur_v    <= 1'b1;
              if (!pf_hit) begin
                state    <= RD_PF;
                mem_addr <= {pf_tag_in, 1'b0};
              end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
              end
            end
          end
        end

        RD_PF: begin
          if (flush) begin
            flush_seen <= 1'b1;
          end
          if (mem_ack) begin
            if (flushed) begin
              cur_v      <= 1'b0;
              pf_v       <= 1'b0;
              flush_seen <= 1'b0;
            end else begin
              pf_data <= mem_rdata;
              pf_tag  <= bus_tag;
              pf_v    <= 1'b1;
            end
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_port.sv
// Directed testbench for fetch_mem_port with a small req/ack memory model.
// The memory model has a programmable number of wait states.
module tb_fetch_mem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_addr;
  logic [15:0] pf_addr;
  logic        flush;
  logic [15:0] fetch_opc;
  logic [15:0] prefetch_opc;
  logic        hold;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255];
  int          wait_states = 0;
  int          wait_cnt = 0;
  logic [15:0] reads[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hc;
  int unst;
  int bad;

  fetch_mem_port #(.ADDR_W(16), .REUSE(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .pc_addr(pc_addr),
    .pf_addr(pf_addr),
    .flush(flush),
    .fetch_opc(fetch_opc),
    .prefetch_opc(prefetch_opc),
    .hold(hold),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory model: ack after wait_states full cycles of request; the counter restarts after each ack.
  assign mem_ack   = mem_req && (wait_cnt == wait_states);
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] pc, input logic [15:0] pf);
    pc_addr = pc;
    pf_addr = pf;
    #1;
  endtask

  task automatic checkRead(input string tag, input int idx, input logic [15:0] expected);
    logic [15:0] got;
    got = (idx < reads.size()) ? reads[idx] : 16'hFFFF;
    checkOutput(tag, {16'h0, got}, {16'h0, expected});
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Runs until hold drops. It counts hold cycles and logs completed reads.
  // It also counts req/addr changes before an ack.
  // An optional one-cycle flush pulse is driven on hold cycle flush_at.
  task automatic measure(input int max_cycles, input int flush_at, output int hold_cycles, output int unstable);
    logic        pending;
    logic [15:0] last_addr;
    hold_cycles = 0;
    unstable    = 0;
    pending     = 1'b0;
    last_addr   = '0;
    reads.delete();
    while (hold && hold_cycles < max_cycles) begin
      if (pending && !(mem_req && mem_addr == last_addr)) unstable++;
      pending   = mem_req && !mem_ack;
      last_addr = mem_addr;
      if (mem_req && mem_ack) reads.push_back(mem_addr);
      flush = (hold_cycles == flush_at);
      hold_cycles++;
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1234;
    mem[8'h02] = 16'h5678;
    mem[8'h04] = 16'h9ABC;
    mem[8'h10] = 16'hDEAD;
    mem[8'h12] = 16'hBEEF;
    flush   = 1'b0;
    pc_addr = 16'h0000;
    pf_addr = 16'h0002;
    $display("[TB] start");

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_hold", hold, 1);
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_fetch", fetch_opc, 0);
    checkOutput("rst_pf", prefetch_opc, 0);
    rst = 1'b0;

    // Cold miss, zero-wait.
    applyStimulus(16'h0000, 16'h0002);
    measure(50, -1, hc, unst);
    checkOutput("t1_hold_cycles", hc, 3);
    checkOutput("t1_nreads", reads.size(), 2);
    checkRead("t1_read0", 0, 16'h0000);
    checkRead("t1_read1", 1, 16'h0002);
    checkOutput("t1_fetch", fetch_opc, 16'h1234);
    checkOutput("t1_pf", prefetch_opc, 16'h5678);
    checkOutput("t1_hold", hold, 0);

    // Sequential advance reuses the prefetch word.
    applyStimulus(16'h0002, 16'h0004);
    measure(50, -1, hc, unst);
    checkOutput("t2_hold_cycles", hc, 2);
    checkOutput("t2_nreads", reads.size(), 1);
    checkRead("t2_read0", 0, 16'h0004);
    checkOutput("t2_fetch", fetch_opc, 16'h5678);
    checkOutput("t2_pf", prefetch_opc, 16'h9ABC);

    // Steady hit, then odd byte addresses of the same words.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (hold !== 1'b0 || mem_req !== 1'b0) bad++;
      tick();
    end
    checkOutput("t5_steady_bad", bad, 0);
    applyStimulus(16'h0003, 16'h0005);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (hold !== 1'b0 || mem_req !== 1'b0) bad++;
      tick();
    end
    checkOutput("t5_odd_bad", bad, 0);
    checkOutput("t5_fetch", fetch_opc, 16'h5678);
    checkOutput("t5_pf", prefetch_opc, 16'h9ABC);

    // Reset in the middle of a pc read.
    wait_states = 3;
    applyStimulus(16'h0010, 16'h0012);
    tick();
    checkOutput("t6_req_before", mem_req, 1);
    checkOutput("t6_addr_before", mem_addr, 16'h0010);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t6_req", mem_req, 0);
    checkOutput("t6_hold", hold, 1);
    checkOutput("t6_fetch", fetch_opc, 0);
    checkOutput("t6_pf", prefetch_opc, 0);
    checkOutput("t6_addr", mem_addr, 0);
    rst = 1'b0;
    wait_states = 0;
    applyStimulus(16'h0000, 16'h0002);
    measure(50, -1, hc, unst);
    checkOutput("t6_hold_cycles", hc, 3);
    checkRead("t6_read0", 0, 16'h0000);
    checkRead("t6_read1", 1, 16'h0002);
    checkOutput("t6_fetch_after", fetch_opc, 16'h1234);
    checkOutput("t6_pf_after", prefetch_opc, 16'h5678);

    // Cold miss with three wait states per read.
    wait_states = 3;
    applyStimulus(16'h0000, 16'h0002);
    doReset();
    measure(100, -1, hc, unst);
    checkOutput("t3_hold_cycles", hc, 9);
    checkOutput("t3_unstable", unst, 0);
    checkOutput("t3_nreads", reads.size(), 2);
    checkRead("t3_read0", 0, 16'h0000);
    checkRead("t3_read1", 1, 16'h0002);
    checkOutput("t3_fetch", fetch_opc, 16'h1234);
    checkOutput("t3_pf", prefetch_opc, 16'h5678);

    // Flush on the second cycle of the prefetch read.
    doReset();
    measure(100, 6, hc, unst);
    checkOutput("t4_hold_cycles", hc, 18);
    checkOutput("t4_unstable", unst, 0);
    checkOutput("t4_nreads", reads.size(), 4);
    checkRead("t4_read0", 0, 16'h0000);
    checkRead("t4_read1", 1, 16'h0002);
    checkRead("t4_read2", 2, 16'h0000);
    checkRead("t4_read3", 3, 16'h0002);
    checkOutput("t4_fetch", fetch_opc, 16'h1234);
    checkOutput("t4_pf", prefetch_opc, 16'h5678);
    checkOutput("t4_hold", hold, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
